// File: rtl/regread_pkg.sv
// Shared types and constants for the register-file read sequencer.
package regread_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Architectural zero register: always reads as zero regardless of mux output.
  localparam logic [4:0] REG_ZERO = 5'd31;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating priority pointer,
// pointer moves past the winner only when the grant is actually taken.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             advance,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  logic             found;

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/regread_arbiter.sv
// Shares the register-file read mux among NREQ requesters: grant, hold the
// select for a full settling cycle, capture the data and buffer the response.
module regread_arbiter
  import regread_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned ID_W   = $clog2(NREQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0][ADDR_W-1:0]  req_addr,
  output logic [NREQ-1:0]              req_ready,
  output logic [ADDR_W-1:0]            mux_sel,
  input  logic [DATA_W-1:0]            mux_data,
  output logic                         rsp_valid,
  output logic [ID_W-1:0]              rsp_id,
  output logic [DATA_W-1:0]            rsp_data,
  input  logic                         rsp_ready
);

  state_e           state;
  logic [NREQ-1:0]  grant;
  logic [ID_W-1:0]  grant_idx;
  logic             any_req;
  logic             grant_en;
  logic             do_grant;

  // Grants are offered when idle or when the held response is being accepted.
  assign any_req   = |req_valid;
  assign grant_en  = (state == IDLE) || (state == RESP && rsp_valid && rsp_ready);
  assign do_grant  = grant_en && any_req;
  assign req_ready = grant_en ? grant : '0;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (reset),
    .req       (req_valid),
    .advance   (do_grant),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mux_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (do_grant) begin
            mux_sel <= req_addr[grant_idx];
            rsp_id  <= grant_idx;
            state   <= SAMPLE;
          end
        end
        SAMPLE: begin
          // Zero-register check uses the latched select, not the live request.
          rsp_data  <= (mux_sel == ADDR_W'(REG_ZERO)) ? '0 : mux_data;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (do_grant) begin
              mux_sel <= req_addr[grant_idx];
              rsp_id  <= grant_idx;
              state   <= SAMPLE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
